// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation slice.
package rsa_pkg;

  // Default operand width for the core, its interface and the modmul unit.
  localparam int RSA_WIDTH = 8;

  // Top-level cycles spent on one modular multiplication:
  // a dispatch cycle, one cycle per operand bit, and the result cycle.
  localparam int MM_CYCLES = RSA_WIDTH + 2;

  // Square-and-multiply sequencer states. The "next bit" bookkeeping has
  // no state of its own because it happens in the modmul result cycle.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REDUCE,
    SQUARE,
    MULT,
    DONE
  } rsa_state_e;

endpackage

// File: rtl/rsa_modexp_core_if.sv
// Control/operand bundle between the RSA control FSM (master) and the
// modular-exponentiation core (slave).
interface rsa_modexp_core_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);
  logic             ena;
  logic             en_rsa;
  logic             rst_rsa;
  logic [WIDTH-1:0] plain;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] cipher;
  logic             eoc_rsa_unit;

  modport master (
    output ena, en_rsa, rst_rsa, plain, exponent, modulus,
    input  cipher, eoc_rsa_unit
  );

  modport slave (
    input  ena, en_rsa, rst_rsa, plain, exponent, modulus,
    output cipher, eoc_rsa_unit
  );
endinterface

// File: rtl/rsa_modmul.sv
// Bit-serial Blakley modular multiplier: p = a*b mod m.
// Timing: start cycle, WIDTH iteration cycles, then one cycle with done=1.
// Requires b < m. a, b and m must stay stable until done.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);

  // Two guard bits: after doubling and adding b the partial product stays
  // below 3m, which always fits in WIDTH+2 bits.
  logic [WIDTH+1:0] p_q;
  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] p_s1;
  logic [WIDTH+1:0] p_nx;
  logic [WIDTH+1:0] m_x;
  logic [WIDTH+1:0] b_x;
  logic [CW-1:0]    cnt;
  logic             run;

  // One Blakley step: shift, add the selected multiplicand, then reduce
  // with up to two subtractions of m.
  // NOTE: every always_comb output gets a default value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    m_x  = {2'b00, m};
    b_x  = a[cnt] ? {2'b00, b} : '0;
    p_sh = (p_q << 1) + b_x;
    p_s1 = (p_sh >= m_x) ? p_sh - m_x : p_sh;
    p_nx = (p_s1 >= m_x) ? p_s1 - m_x : p_s1;
  end

  // Iteration counter and partial product, frozen whenever ena or en is low.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      p_q  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (ena && en) begin
      if (abort) begin
        cnt  <= '0;
        run  <= 1'b0;
        done <= 1'b0;
      end else if (start) begin
        p_q  <= '0;
        cnt  <= CW'(WIDTH - 1);
        run  <= 1'b1;
        done <= 1'b0;
      end else if (run) begin
        p_q <= p_nx;
        if (cnt == '0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else begin
        done <= 1'b0;
      end
    end
  end

  assign p = p_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply: cipher = plain^exponent mod modulus.
// Optional build macro RSA_EARLY_EXIT_EN: start scanning the exponent at
// its most significant 1 instead of at bit WIDTH-1 (same results, fewer
// modmuls). The default build scans all WIDTH bits.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic            clk,
  input  logic            rstb,
  rsa_modexp_core_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  rsa_state_e       state;
  rsa_state_e       state_n;
  logic [WIDTH-1:0] plain_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] cipher_q;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_p;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_init;
  logic             eoc_q;
  logic             mm_issued;
  logic             mm_start;
  logic             mm_done;
  logic             mm_abort;
  logic             advance;
  logic             last_bit;
  logic             skip_all;

  assign advance  = bus.ena && bus.en_rsa;
  assign mm_abort = !bus.rst_rsa;
  assign last_bit = (idx == '0);

`ifdef RSA_EARLY_EXIT_EN
  function automatic logic [IW-1:0] msb_of(input logic [WIDTH-1:0] v);
    msb_of = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) msb_of = IW'(i);
    end
  endfunction

  assign idx_init = msb_of(bus.exponent);
  assign skip_all = (exp_r == '0);
`else
  assign idx_init = IW'(WIDTH - 1);
  assign skip_all = 1'b0;
`endif

  // Sequencer register; only moves on advance cycles.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else if (advance) begin
      state <= state_n;
    end
  end

  // Next state: soft reset wins, otherwise step when the modmul finishes.
  always_comb begin
    state_n = state;
    if (!bus.rst_rsa) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    state_n = LOAD;
        LOAD:    state_n = (bus.modulus < WIDTH'(2)) ? DONE : REDUCE;
        REDUCE:  if (mm_done) state_n = skip_all ? DONE : SQUARE;
        SQUARE:  if (mm_done) state_n = exp_r[idx] ? MULT : (last_bit ? DONE : SQUARE);
        MULT:    if (mm_done) state_n = last_bit ? DONE : SQUARE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Modmul dispatch and operand selection for the current operation.
  always_comb begin
    mm_start = (state inside {REDUCE, SQUARE, MULT}) && !mm_issued;
    mm_a     = acc;
    mm_b     = acc;
    if (state == REDUCE) begin
      mm_a = plain_r;
      mm_b = WIDTH'(1);
    end else if (state == MULT) begin
      mm_b = base;
    end
  end

  // Operand capture, accumulator/bit-index bookkeeping and result/eoc
  // registers. cipher deliberately survives a soft reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      plain_r   <= '0;
      exp_r     <= '0;
      mod_r     <= '0;
      acc       <= '0;
      base      <= '0;
      idx       <= '0;
      cipher_q  <= '0;
      eoc_q     <= 1'b0;
      mm_issued <= 1'b0;
    end else if (advance) begin
      eoc_q <= bus.rst_rsa && (state == DONE);
      if (!bus.rst_rsa) begin
        mm_issued <= 1'b0;
      end else begin
        if (mm_start)     mm_issued <= 1'b1;
        else if (mm_done) mm_issued <= 1'b0;
        case (state)
          LOAD: begin
            plain_r <= bus.plain;
            exp_r   <= bus.exponent;
            mod_r   <= bus.modulus;
            acc     <= WIDTH'(1);
            idx     <= idx_init;
            if (bus.modulus < WIDTH'(2)) cipher_q <= '0;
          end
          REDUCE: if (mm_done) begin
            base <= mm_p;
            if (skip_all) cipher_q <= acc;
          end
          SQUARE, MULT: if (mm_done) begin
            acc <= mm_p;
            // Bit finished unless a square is about to be followed by a multiply.
            if (state == MULT || !exp_r[idx]) begin
              if (last_bit) cipher_q <= mm_p;
              else          idx      <= idx - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (bus.ena),
    .en    (bus.en_rsa),
    .abort (mm_abort),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mod_r),
    .done  (mm_done),
    .p     (mm_p)
  );

  assign bus.cipher       = cipher_q;
  assign bus.eoc_rsa_unit = eoc_q;

endmodule
